arcade_rom_loader: RTL
======================

// Module: arcade_rom_loader
// PURPOSE
//  Routes the HPS ioctl download stream into NUM_REGIONS ROM regions (main CPU, sound CPU, gfx, PROMs).
//  Generalises the single flat dn_addr/dn_data/dn_wr hookup so that region selection is decoded once, here.
//  Tracks per-region completion, flags stray writes and generates the core reset around each download.
//  Sits in the emu top level between hps_io and the game core; everything runs in the clk_sys domain.
// PARAMETERS
//  NUM_REGIONS  4           number of ROM regions, 1..8
//  REGION_AW    16          width of rom_addr, i.e. region-relative offset
//  REGION_BASE  {4{25'h0}}  packed NUM_REGIONS x 25b start addresses; region i is in bits [25*i +: 25]
//  REGION_SIZE  {4{25'h0}}  packed NUM_REGIONS x 25b sizes in bytes, each 1..2**REGION_AW
//  ROM_INDEX    8'd0        ioctl_index value that selects ROM downloads; any other index is ignored
//  HOLD_CYCLES  16          number of clk_sys cycles core_reset stays high after a download ends, 1..65535
// PORTS
//  clk_sys         in   1             system clock
//  reset           in   1             asynchronous, active-high
//  ioctl_download  in   1             download active (from hps_io)
//  ioctl_index     in   8             download index
//  ioctl_wr        in   1             one-cycle byte-write strobe
//  ioctl_addr      in   25            absolute byte address
//  ioctl_dout      in   8             byte data
//  rom_we          out  NUM_REGIONS   one-hot write strobe per region
//  rom_addr        out  REGION_AW     region-relative address, equal to ioctl_addr - REGION_BASE[i]
//  rom_data        out  8             registered copy of ioctl_dout
//  loaded          out  NUM_REGIONS   region i has received at least REGION_SIZE[i] writes
//  dl_done         out  1             one-cycle pulse when a ROM_INDEX download ends
//  stray_err       out  1             sticky: a write hit no region
//  core_reset      out  1             hold the game core in reset
//  checksum        out  16*NUM_REGIONS  per-region byte sums; present only with ARCADE_ROM_LOADER_CKSUM_EN
// BEHAVIOUR
//  Reset values: rom_we=0, rom_addr=0, rom_data=0, loaded=0, dl_done=0, stray_err=0, core_reset=1, FSM=HOLD with hold count = HOLD_CYCLES.
//  active = ioctl_download && ioctl_index==ROM_INDEX. Its rise and fall edges come from a registered copy of active.
//  Decode: region i is hit when BASE[i] <= addr < BASE[i]+SIZE[i]. If regions overlap, the lowest index wins.
//  Write path, latency 1: if ioctl_wr && active, then on the next edge rom_we = onehot(hit), rom_addr = offset[REGION_AW-1:0], rom_data = dout.
//    rom_we lasts exactly one cycle per ioctl_wr. ioctl_wr while not active produces nothing.
//  No hit: rom_we stays 0 and stray_err is set. stray_err is cleared only by reset or by an active rise.
//  Counters: each region has a 25b write counter, cleared on an active rise.
//    The counter increments on each hit write and saturates at SIZE[i]. Duplicate addresses are counted.
//    loaded[i] = (count==SIZE[i]). loaded is cleared on an active rise.
//  Simultaneous active rise and write in the same cycle: the clear takes priority and that write then counts, so count=1.
//  FSM IDLE/LOAD/HOLD:
//    IDLE: core_reset=0. Goes to LOAD on an active rise.
//    LOAD: core_reset=1. On an active fall: dl_done pulses, hold count = HOLD_CYCLES, go to HOLD.
//    HOLD: core_reset=1 and the count decrements each cycle. At count==1, go to IDLE on the next edge. An active rise in HOLD goes to LOAD.
//  core_reset falls exactly HOLD_CYCLES cycles after the fall edge is registered.
//  Reset mid-download: all state is cleared and the FSM enters HOLD. The remaining bytes of that download are still routed, but loaded cannot complete.
//  Downloads with a non-ROM index never change state.
// CONFIGURATION
//  ARCADE_ROM_LOADER_CKSUM_EN defined: per-region 16b wrapping sum of written bytes.
//    Cleared together with the counters and updated in the same cycle as rom_we. Not updated once the counter saturates.
//  Not defined: the checksum port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  Package arcade_rom_loader_pkg holds: typedef enum logic[1:0] {IDLE, LOAD, HOLD} ldr_state_t, ADDR_W=25, CKSUM_W=16,
//    and the function region_field(packed, i) that extracts a 25b field.
//  Sub-module arcade_rom_region_track is instantiated once per region through generate.
//    It holds the counter, loaded and the optional checksum, with inputs clr, hit_wr, data.
//  The top level holds the decode, the write register, edge detection, the FSM and stray_err.
// TESTING
//  Use NUM_REGIONS=3 with BASE={0x0000,0x8000,0xA000}, SIZE={0x8000,0x2000,0x0100}, HOLD_CYCLES=4.
//  1. Full download at index 0, 0x0000..0xA0FF -> loaded=3'b111, stray_err=0, dl_done pulses once,
//     core_reset=1 from the rise until 4 cycles after the fall.
//  2. Write at addr 0x8005, data 0x5A -> one cycle later rom_we=3'b010, rom_addr=0x0005, rom_data=0x5A, for exactly one cycle.
//  3. Write at addr 0xA100 -> rom_we stays 0 and stray_err=1 until the next download rise, which clears it.
//  4. Download at ioctl_index=1 with 0x100 writes -> no rom_we, counts unchanged, core_reset unchanged.
//  5. Assert reset after 0x4000 bytes, release it, then finish the download -> loaded[0]=0, core_reset=1,
//     and the region 0 writes continue without error.
//  6. CKSUM_EN: region 2 loaded with 0x100 bytes of 0xFF -> checksum[47:32]=16'hFF00. A new download rise clears it to 0.

Source files
------------

// File: rtl/arcade_rom_loader_pkg.sv
// rtl/arcade_rom_loader_pkg.sv - shared types, widths and field helper for the ROM loader
//
// Holds the loader FSM state type, the absolute address and checksum widths, and
// region_field(), which pulls one 25-bit entry out of a packed per-region table.
// Tables narrower than MAX_REGIONS entries are zero-extended by the caller.
package arcade_rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } ldr_state_t;

    localparam int ADDR_W      = 25;
    localparam int CKSUM_W     = 16;
    localparam int MAX_REGIONS = 8;

    function automatic logic [ADDR_W-1:0] region_field(
        input logic [MAX_REGIONS*ADDR_W-1:0] fields,
        input int                            idx
    );
        return fields[idx*ADDR_W +: ADDR_W];
    endfunction

endpackage

// File: rtl/arcade_rom_region_track.sv
// rtl/arcade_rom_region_track.sv - per-region write counter, loaded flag and optional checksum
//
// Optional feature: ARCADE_ROM_LOADER_CKSUM_EN adds the data input and checksum output.
// Ports:
//   clk_sys, reset  system clock, asynchronous active-high reset
//   clr             start of a new ROM download; counter and checksum restart
//   hit_wr          a write landed in this region this cycle
//   data            written byte (checksum build only)
//   checksum        16b wrapping sum of counted bytes (checksum build only)
//   loaded          region has received SIZE writes
module arcade_rom_region_track
    import arcade_rom_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SIZE = 25'd1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               clr,
    input  logic               hit_wr,
`ifdef ARCADE_ROM_LOADER_CKSUM_EN
    input  logic [7:0]         data,
    output logic [CKSUM_W-1:0] checksum,
`endif
    output logic               loaded
);

    logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_base;
    logic              bump;

    // A clear and a write in the same cycle: the write counts against the
    // freshly cleared value, so the first byte of a download is never lost.
    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        bump     = hit_wr && (cnt_base != SIZE);
        cnt_d    = bump ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign loaded = (cnt_q == SIZE);

`ifdef ARCADE_ROM_LOADER_CKSUM_EN
    logic [CKSUM_W-1:0] sum_q, sum_d;

    // Only bytes that advance the counter are summed, so a region that is
    // over-written after saturation keeps the checksum of its first SIZE bytes.
    always_comb begin
        sum_d = clr ? '0 : sum_q;
        if (bump) begin
            sum_d = sum_d + {{(CKSUM_W-8){1'b0}}, data};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: rtl/arcade_rom_loader.sv
// rtl/arcade_rom_loader.sv - routes the ioctl ROM download into per-region ROM write ports
//
// Optional feature: define ARCADE_ROM_LOADER_CKSUM_EN for per-region byte checksums.
// Ports:
//   clk_sys, reset             system clock, asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout   download stream from hps_io
//   rom_we, rom_addr, rom_data registered one-hot region write port, latency 1
//   loaded                     per-region completion flags
//   dl_done                    one-cycle pulse when a ROM download ends
//   stray_err                  sticky: a ROM write hit no region
//   core_reset                 holds the game core in reset around downloads
//   checksum                   per-region 16b byte sums (checksum build only)
module arcade_rom_loader
    import arcade_rom_loader_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            REGION_AW   = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {4{25'h0}},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {4{25'h0}},
    parameter logic [7:0]                    ROM_INDEX   = 8'd0,
    parameter int                            HOLD_CYCLES = 16
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic                           ioctl_download,
    input  logic [7:0]                     ioctl_index,
    input  logic                           ioctl_wr,
    input  logic [ADDR_W-1:0]              ioctl_addr,
    input  logic [7:0]                     ioctl_dout,
    output logic [NUM_REGIONS-1:0]         rom_we,
    output logic [REGION_AW-1:0]           rom_addr,
    output logic [7:0]                     rom_data,
    output logic [NUM_REGIONS-1:0]         loaded,
    output logic                           dl_done,
    output logic                           stray_err,
`ifdef ARCADE_ROM_LOADER_CKSUM_EN
    output logic [CKSUM_W*NUM_REGIONS-1:0] checksum,
`endif
    output logic                           core_reset
);

    localparam logic [MAX_REGIONS*ADDR_W-1:0] BASE_X    = (MAX_REGIONS*ADDR_W)'(REGION_BASE);
    localparam logic [MAX_REGIONS*ADDR_W-1:0] SIZE_X    = (MAX_REGIONS*ADDR_W)'(REGION_SIZE);
    localparam logic [15:0]                   HOLD_INIT = 16'(HOLD_CYCLES);

    // ---------------- download edges ----------------
    logic active, active_q, rise, fall, wr_en;

    assign active = ioctl_download && (ioctl_index == ROM_INDEX);
    assign rise   = active && !active_q;
    assign fall   = !active && active_q;
    assign wr_en  = ioctl_wr && active;

    // ---------------- region decode ----------------
    logic [ADDR_W:0]       diff   [NUM_REGIONS];
    logic [ADDR_W-1:0]     size_a [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] hit, sel_onehot;
    logic [REGION_AW-1:0]  sel_off;
    logic                  any_hit;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE_G = region_field(BASE_X, g);
        localparam logic [ADDR_W-1:0] SIZE_G = region_field(SIZE_X, g);

        // One extra bit catches addresses below the base (borrow out),
        // the low bits double as the region-relative offset.
        assign size_a[g] = SIZE_G;
        assign diff[g]   = {1'b0, ioctl_addr} - {1'b0, BASE_G};
        assign hit[g]    = !diff[g][ADDR_W] && (diff[g][ADDR_W-1:0] < size_a[g]);

        arcade_rom_region_track #(
            .SIZE     (SIZE_G)
        ) u_track (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .clr      (rise),
            .hit_wr   (wr_en && sel_onehot[g]),
`ifdef ARCADE_ROM_LOADER_CKSUM_EN
            .data     (ioctl_dout),
            .checksum (checksum[g*CKSUM_W +: CKSUM_W]),
`endif
            .loaded   (loaded[g])
        );
    end

    // Scan from the top down so the lowest-index overlapping region wins.
    always_comb begin
        sel_onehot = '0;
        sel_off    = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_off       = diff[i][REGION_AW-1:0];
            end
        end
    end

    assign any_hit = |hit;

    // ---------------- write register and stray flag ----------------
    logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
    logic [REGION_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]             rom_data_q, rom_data_d;
    logic                   stray_q, stray_d;

    always_comb begin
        rom_we_d   = '0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        stray_d    = rise ? 1'b0 : stray_q;
        if (wr_en) begin
            rom_data_d = ioctl_dout;
            if (any_hit) begin
                rom_we_d   = sel_onehot;
                rom_addr_d = sel_off;
            end else begin
                stray_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active_q   <= 1'b0;
            rom_we_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            stray_q    <= 1'b0;
        end else begin
            active_q   <= active;
            rom_we_q   <= rom_we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            stray_q    <= stray_d;
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_data  = rom_data_q;
    assign stray_err = stray_q;

    // ---------------- core reset FSM ----------------
    ldr_state_t  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        dl_done_q, dl_done_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            hold_q    <= HOLD_INIT;
            dl_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            dl_done_q <= dl_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        dl_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fall) begin
                    state_d   = HOLD;
                    hold_d    = HOLD_INIT;
                    dl_done_d = 1'b1;
                end
            end
            HOLD: begin
                hold_d = hold_q - 16'd1;
                if (rise) begin
                    state_d = LOAD;
                end else if (hold_q == 16'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = HOLD;
                hold_d  = HOLD_INIT;
            end
        endcase
    end

    assign dl_done    = dl_done_q;
    assign core_reset = (state_q != IDLE);

endmodule
